// File: rtl/matrix_rd_arbiter_if.sv
// AXI4 read-channel bundle for the shared HBM/DDR master port.
// The arbiter uses the master modport; the memory side, or a bench standing in
// for it, uses the slave modport.
interface matrix_rd_arbiter_if #(
    parameter int ID_W = 2
);
    // AR channel
    logic            m_arvalid;
    logic            m_arready;
    logic [31:0]     m_araddr;
    logic [7:0]      m_arlen;
    logic [ID_W-1:0] m_arid;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_arlock;
    logic [3:0]      m_arcache;
    logic [3:0]      m_arqos;
    logic [3:0]      m_arregion;
    logic [2:0]      m_arprot;
    // R channel
    logic            m_rvalid;
    logic            m_rready;
    logic [511:0]    m_rdata;
    logic            m_rlast;
    logic [ID_W-1:0] m_rid;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst,
               m_arlock, m_arcache, m_arqos, m_arregion, m_arprot, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rlast, m_rid
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst,
               m_arlock, m_arcache, m_arqos, m_arregion, m_arprot, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rlast, m_rid
    );
endinterface

// File: rtl/matrix_rd_arbiter.sv
// Round-robin AR arbiter sharing one AXI4 read master among NUM_REQ matrix
// read engines. The requester index travels on arid; R beats are steered back
// by rid. A per-requester outstanding-burst cap keeps any single engine from
// hogging the port.
//
// Handshake rule on every channel: a transfer happens in the cycle where
// valid and ready are both high. A source that raised valid holds it and its
// payload stable until that cycle; ready may depend combinationally on valid.
module matrix_rd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ID_W      = 2,
    parameter int MAX_OUTST = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    // requester AR side
    input  logic [NUM_REQ-1:0]       s_arvalid,
    output logic [NUM_REQ-1:0]       s_arready,
    input  logic [NUM_REQ-1:0][31:0] s_araddr,
    input  logic [NUM_REQ-1:0][7:0]  s_arlen,
    // requester R side
    output logic [NUM_REQ-1:0]       s_rvalid,
    input  logic [NUM_REQ-1:0]       s_rready,
    output logic [511:0]             s_rdata,
    output logic                     s_rlast,
    // shared master port
    matrix_rd_arbiter_if.master      m_axi,
    // status
    output logic [NUM_REQ-1:0][7:0]  outst_cnt,
    output logic [NUM_REQ-1:0][31:0] grant_cnt,
    output logic [31:0]              rid_err_cnt,
    output logic                     dbg_ar_full
);

    typedef enum logic {
        AR_EMPTY = 1'b0,
        AR_FULL  = 1'b1
    } ar_state_e;

    localparam logic [7:0]      MAX_L   = 8'(MAX_OUTST);
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    ar_state_e                 state_q, state_d;
    logic [31:0]               araddr_q, araddr_d;
    logic [7:0]                arlen_q, arlen_d;
    logic [ID_W-1:0]           arid_q, arid_d;
    logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][7:0]   outst_q, outst_d;
    logic [NUM_REQ-1:0][31:0]  grant_q, grant_d;
    logic [31:0]               rid_err_q, rid_err_d;

    logic [NUM_REQ-1:0]        rid_match;
    logic [NUM_REQ-1:0]        retire;
    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        grant;
    logic                      rid_ok;
    logic                      rready_c;
    logic                      load;
    logic                      any_grant;
    logic [ID_W-1:0]           win_id;

    // Decode rid; out-of-range IDs are swallowed so the memory never stalls on them.
    always_comb begin
        rid_match = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rid_match[i] = (m_axi.m_rid == ID_W'(i));
        end
        rid_ok   = |rid_match;
        rready_c = 1'b0;
        if (rstn) begin
            rready_c = rid_ok ? |(rid_match & s_rready) : 1'b1;
        end
    end

    // Last-beat retirement per requester, used by both the cap check and the counters.
    always_comb begin
        retire = rid_match & {NUM_REQ{m_axi.m_rvalid & rready_c & m_axi.m_rlast}};
    end

    // Eligibility and round-robin pick starting just after the previous winner.
    always_comb begin
        load      = rstn && ((state_q == AR_EMPTY) || m_axi.m_arready);
        eligible  = '0;
        grant     = '0;
        any_grant = 1'b0;
        win_id    = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = s_arvalid[i] &&
                          ((outst_q[i] < MAX_L) || ((outst_q[i] == MAX_L) && retire[i]));
        end
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (load && !any_grant && eligible[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                win_id     = ID_W'(idx);
            end
        end
    end

    // Next-state for the AR register, pointer and all counters.
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        rr_ptr_d  = rr_ptr_q;
        outst_d   = outst_q;
        grant_d   = grant_q;
        rid_err_d = rid_err_q;
        if (load) begin
            if (any_grant) begin
                state_d  = AR_FULL;
                arid_d   = win_id;
                rr_ptr_d = win_id;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant[i]) begin
                        araddr_d = s_araddr[i];
                        arlen_d  = s_arlen[i];
                    end
                end
            end else begin
                state_d = AR_EMPTY;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            // A grant and a retire together cancel; a lone retire floors at zero.
            case ({grant[i], retire[i]})
                2'b10:   outst_d[i] = outst_q[i] + 8'd1;
                2'b01:   outst_d[i] = (outst_q[i] != 8'd0) ? outst_q[i] - 8'd1 : 8'd0;
                default: outst_d[i] = outst_q[i];
            endcase
            grant_d[i] = grant_q[i] + 32'(grant[i]);
        end
        rid_err_d = rid_err_q + 32'(m_axi.m_rvalid && rready_c && !rid_ok);
    end

    // State register; reset drops any pending AR and clears every counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= AR_EMPTY;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            rr_ptr_q  <= PTR_RST;
            outst_q   <= '0;
            grant_q   <= '0;
            rid_err_q <= '0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            rr_ptr_q  <= rr_ptr_d;
            outst_q   <= outst_d;
            grant_q   <= grant_d;
            rid_err_q <= rid_err_d;
        end
    end

    assign s_arready         = grant;
    assign s_rvalid          = rid_match & {NUM_REQ{m_axi.m_rvalid}};
    assign s_rdata           = m_axi.m_rdata;
    assign s_rlast           = m_axi.m_rlast;

    assign m_axi.m_rready    = rready_c;
    assign m_axi.m_arvalid   = (state_q == AR_FULL);
    assign m_axi.m_araddr    = araddr_q;
    assign m_axi.m_arlen     = arlen_q;
    assign m_axi.m_arid      = arid_q;
    assign m_axi.m_arsize    = 3'b110;
    assign m_axi.m_arburst   = 2'b01;
    assign m_axi.m_arlock    = 1'b0;
    assign m_axi.m_arcache   = 4'd0;
    assign m_axi.m_arqos     = 4'd0;
    assign m_axi.m_arregion  = 4'd0;
    assign m_axi.m_arprot    = 3'b010;

    assign outst_cnt         = outst_q;
    assign grant_cnt         = grant_q;
    assign rid_err_cnt       = rid_err_q;
    assign dbg_ar_full       = (state_q == AR_FULL);

endmodule

// File: tb/tb_matrix_rd_arbiter.sv
// Bench for matrix_rd_arbiter: directed scenarios plus randomized traffic,
// all checked each cycle against a transaction-level model and an AR queue.
`timescale 1ns/1ps
module tb_matrix_rd_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int ID_W      = 2;
    localparam int MAX_OUTST = 4;
    localparam int W         = ID_W + 40;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]       s_arvalid;
    logic [NUM_REQ-1:0]       s_arready;
    logic [NUM_REQ-1:0][31:0] s_araddr;
    logic [NUM_REQ-1:0][7:0]  s_arlen;
    logic [NUM_REQ-1:0]       s_rvalid;
    logic [NUM_REQ-1:0]       s_rready;
    logic [511:0]             s_rdata;
    logic                     s_rlast;
    logic [NUM_REQ-1:0][7:0]  outst_cnt;
    logic [NUM_REQ-1:0][31:0] grant_cnt;
    logic [31:0]              rid_err_cnt;
    logic                     dbg_ar_full;

    matrix_rd_arbiter_if #(.ID_W(ID_W)) m_axi ();

    matrix_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rlast(s_rlast),
        .m_axi(m_axi),
        .outst_cnt(outst_cnt), .grant_cnt(grant_cnt),
        .rid_err_cnt(rid_err_cnt), .dbg_ar_full(dbg_ar_full)
    );

    // ---------------- scoreboard / model state ----------------
    int                errors = 0;
    int                checks = 0;
    logic [W-1:0]      exp_q[$];
    bit                mdl_full = 1'b0;
    int                mdl_last = NUM_REQ - 1;
    int                mdl_outst[NUM_REQ];
    logic [31:0]       mdl_grant[NUM_REQ];
    logic [31:0]       mdl_err = '0;
    int                exp_win;
    int                exp_retire;
    bit                exp_bad_beat;
    logic [NUM_REQ-1:0] exp_arready;
    logic [NUM_REQ-1:0] exp_rvalid;
    logic              exp_rready;
    logic [NUM_REQ-1:0] obs_arready;
    logic [NUM_REQ-1:0] obs_rvalid;
    logic              obs_rready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // What the arbiter should do this cycle, from the current model state and inputs.
    task automatic model_comb();
        int  rid;
        bit  rid_ok;
        rid    = int'(m_axi.m_rid);
        rid_ok = (rid < NUM_REQ);
        exp_rready = 1'b0;
        if (rstn) begin
            if (rid_ok) exp_rready = s_rready[rid];
            else        exp_rready = 1'b1;
        end
        exp_rvalid = '0;
        if (m_axi.m_rvalid && rid_ok) exp_rvalid[rid] = 1'b1;
        exp_retire   = (m_axi.m_rvalid && exp_rready && m_axi.m_rlast && rid_ok) ? rid : -1;
        exp_bad_beat = m_axi.m_rvalid && exp_rready && !rid_ok;
        exp_win = -1;
        if (rstn && (!mdl_full || m_axi.m_arready)) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (mdl_last + k) % NUM_REQ;
                if (exp_win < 0 && s_arvalid[c] &&
                    (mdl_outst[c] < MAX_OUTST || (mdl_outst[c] == MAX_OUTST && exp_retire == c)))
                    exp_win = c;
            end
        end
        exp_arready = '0;
        if (exp_win >= 0) exp_arready[exp_win] = 1'b1;
    endtask

    // Advance the model across the clock edge.
    task automatic model_next();
        if (!rstn) begin
            mdl_full = 1'b0;
            mdl_last = NUM_REQ - 1;
            mdl_err  = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                mdl_outst[i] = 0;
                mdl_grant[i] = '0;
            end
            exp_q.delete();
        end else begin
            if (!mdl_full || m_axi.m_arready) begin
                if (exp_win >= 0) begin
                    mdl_full = 1'b1;
                    mdl_last = exp_win;
                    mdl_outst[exp_win]++;
                    mdl_grant[exp_win] = mdl_grant[exp_win] + 32'd1;
                    exp_q.push_back({ID_W'(exp_win), s_arlen[exp_win], s_araddr[exp_win]});
                end else begin
                    mdl_full = 1'b0;
                end
            end
            if (exp_retire >= 0 && mdl_outst[exp_retire] > 0) mdl_outst[exp_retire]--;
            if (exp_bad_beat) mdl_err = mdl_err + 32'd1;
        end
    endtask

    // One clock: inputs are already applied just after the falling edge.
    task automatic cycle();
        logic [W-1:0] exp_ar;
        #1;
        model_comb();
        obs_arready = s_arready;
        obs_rvalid  = s_rvalid;
        obs_rready  = m_axi.m_rready;
        chk("s_arready", 64'(s_arready), 64'(exp_arready));
        chk("m_rready", 64'(m_axi.m_rready), 64'(exp_rready));
        chk("s_rvalid", 64'(s_rvalid), 64'(exp_rvalid));
        chk("s_rdata_lo", s_rdata[63:0], m_axi.m_rdata[63:0]);
        chk("s_rdata_hi", s_rdata[511:448], m_axi.m_rdata[511:448]);
        chk("s_rlast", 64'(s_rlast), 64'(m_axi.m_rlast));
        if (rstn && m_axi.m_arvalid && m_axi.m_arready) begin
            if (exp_q.size() == 0) begin
                chk("ar_fire_unexpected", 64'(m_axi.m_arvalid), 64'(mdl_full));
            end else begin
                exp_ar = exp_q.pop_front();
                chk("ar_fire", 64'({m_axi.m_arid, m_axi.m_arlen, m_axi.m_araddr}), 64'(exp_ar));
            end
        end
        model_next();
        @(posedge clk);
        #1;
        chk("m_arvalid", 64'(m_axi.m_arvalid), 64'(mdl_full));
        chk("dbg_ar_full", 64'(dbg_ar_full), 64'(mdl_full));
        if (mdl_full && exp_q.size() > 0)
            chk("ar_hold", 64'({m_axi.m_arid, m_axi.m_arlen, m_axi.m_araddr}), 64'(exp_q[0]));
        for (int i = 0; i < NUM_REQ; i++) begin
            chk($sformatf("outst_cnt[%0d]", i), 64'(outst_cnt[i]), 64'(mdl_outst[i]));
            chk($sformatf("grant_cnt[%0d]", i), 64'(grant_cnt[i]), 64'(mdl_grant[i]));
        end
        chk("rid_err_cnt", 64'(rid_err_cnt), 64'(mdl_err));
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clr_inputs();
        s_arvalid       = '0;
        s_araddr        = '0;
        s_arlen         = '0;
        s_rready        = '0;
        m_axi.m_arready = 1'b0;
        m_axi.m_rvalid  = 1'b0;
        m_axi.m_rdata   = '0;
        m_axi.m_rlast   = 1'b0;
        m_axi.m_rid     = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
    endtask

    bit rr_seq[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int beat;
        clr_inputs();
        @(negedge clk);
        do_reset();
        do_reset();

        // reset state and fixed AR fields
        chk("rst_m_arvalid", 64'(m_axi.m_arvalid), 64'd0);
        chk("rst_m_araddr", 64'(m_axi.m_araddr), 64'd0);
        chk("rst_m_arlen", 64'(m_axi.m_arlen), 64'd0);
        chk("rst_m_arid", 64'(m_axi.m_arid), 64'd0);
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        chk("rst_outst_cnt", 64'(outst_cnt), 64'd0);
        chk("rst_rid_err", 64'(rid_err_cnt), 64'd0);
        chk("arsize", 64'(m_axi.m_arsize), 64'h6);
        chk("arburst", 64'(m_axi.m_arburst), 64'h1);
        chk("arprot", 64'(m_axi.m_arprot), 64'h2);
        chk("arlock_cache_qos_region",
            64'({m_axi.m_arlock, m_axi.m_arcache, m_axi.m_arqos, m_axi.m_arregion}), 64'd0);

        // single requester, back-to-back
        m_axi.m_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_arvalid   = 2'b01;
            s_araddr[0] = 32'(i * 64);
            cycle();
            chk("single_arready", 64'(obs_arready), 64'h1);
            chk("single_arvalid", 64'(m_axi.m_arvalid), 64'd1);
            chk("single_arid", 64'(m_axi.m_arid), 64'd0);
            chk("single_araddr", 64'(m_axi.m_araddr), 64'(i * 64));
        end
        s_arvalid = '0;
        cycle();
        chk("single_grant_cnt0", 64'(grant_cnt[0]), 64'd4);

        // fairness
        do_reset();
        m_axi.m_arready = 1'b1;
        s_arvalid   = 2'b11;
        s_araddr[0] = 32'h100;
        s_araddr[1] = 32'h200;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("fair_order", 64'(obs_arready), 64'(1 << (k % 2)));
        end
        s_arvalid = '0;
        cycle();
        chk("fair_grant0", 64'(grant_cnt[0]), 64'd4);
        chk("fair_grant1", 64'(grant_cnt[1]), 64'd4);

        // backpressure
        do_reset();
        s_arvalid   = 2'b11;
        s_araddr[0] = 32'h1000;
        s_araddr[1] = 32'h2000;
        s_arlen[0]  = 8'd3;
        s_arlen[1]  = 8'd5;
        cycle();
        chk("bp_first", 64'(obs_arready), 64'h1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_arready", 64'(obs_arready), 64'h0);
            chk("bp_araddr", 64'(m_axi.m_araddr), 64'h1000);
            chk("bp_arlen", 64'(m_axi.m_arlen), 64'd3);
            chk("bp_arid", 64'(m_axi.m_arid), 64'd0);
        end
        m_axi.m_arready = 1'b1;
        cycle();
        chk("bp_next", 64'(obs_arready), 64'h2);
        chk("bp_next_addr", 64'(m_axi.m_araddr), 64'h2000);
        chk("bp_next_id", 64'(m_axi.m_arid), 64'd1);

        // outstanding limit
        do_reset();
        m_axi.m_arready = 1'b1;
        s_arvalid = 2'b01;
        for (int k = 0; k < 6; k++) cycle();
        chk("lim_stalled", 64'(obs_arready), 64'h0);
        chk("lim_grant0", 64'(grant_cnt[0]), 64'(MAX_OUTST));
        s_arvalid = 2'b11;
        cycle();
        chk("lim_other", 64'(obs_arready), 64'h2);
        m_axi.m_rvalid = 1'b1;
        m_axi.m_rid    = 2'd0;
        m_axi.m_rlast  = 1'b1;
        s_rready       = 2'b01;
        cycle();
        chk("lim_same_cycle", 64'(obs_arready), 64'h1);
        chk("lim_outst0", 64'(outst_cnt[0]), 64'(MAX_OUTST));
        clr_inputs();
        cycle();

        // R routing with requester backpressure
        do_reset();
        m_axi.m_arready = 1'b1;
        s_arvalid = 2'b10;
        cycle();
        s_arvalid = '0;
        cycle();
        beat = 0;
        for (int k = 0; k < 5; k++) begin
            m_axi.m_rvalid = 1'b1;
            m_axi.m_rid    = 2'd1;
            m_axi.m_rlast  = (beat == 3);
            m_axi.m_rdata  = {16{$urandom}};
            s_rready       = {rr_seq[k], 1'b0};
            cycle();
            chk("r_rready", 64'(obs_rready), 64'(rr_seq[k]));
            chk("r_svalid0", 64'(obs_rvalid[0]), 64'd0);
            chk("r_outst1", 64'(outst_cnt[1]), (k == 4) ? 64'd0 : 64'd1);
            if (rr_seq[k]) beat++;
        end
        clr_inputs();

        // bad ID then reset with a pending AR
        m_axi.m_rvalid = 1'b1;
        m_axi.m_rid    = 2'd3;
        m_axi.m_rlast  = 1'b1;
        cycle();
        chk("bad_rready", 64'(obs_rready), 64'd1);
        chk("bad_svalid", 64'(obs_rvalid), 64'd0);
        chk("bad_err_cnt", 64'(rid_err_cnt), 64'd1);
        clr_inputs();
        s_arvalid = 2'b01;
        cycle();
        chk("pend_arvalid", 64'(m_axi.m_arvalid), 64'd1);
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        chk("rst_drop_arvalid", 64'(m_axi.m_arvalid), 64'd0);
        chk("rst_clr_grant", 64'(grant_cnt), 64'd0);
        chk("rst_clr_outst", 64'(outst_cnt), 64'd0);
        chk("rst_clr_err", 64'(rid_err_cnt), 64'd0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            rstn            = ($urandom_range(0, 99) != 0);
            s_arvalid       = NUM_REQ'($urandom_range(0, 3));
            for (int i = 0; i < NUM_REQ; i++) begin
                s_araddr[i] = $urandom;
                s_arlen[i]  = 8'($urandom_range(0, 255));
            end
            m_axi.m_arready = ($urandom_range(0, 3) != 0);
            m_axi.m_rvalid  = ($urandom_range(0, 1) != 0);
            m_axi.m_rid     = ($urandom_range(0, 7) != 0) ? ID_W'($urandom_range(0, 1))
                                                          : ID_W'($urandom_range(2, 3));
            m_axi.m_rlast   = ($urandom_range(0, 2) == 0);
            m_axi.m_rdata   = {16{$urandom}};
            s_rready        = NUM_REQ'($urandom_range(0, 3));
            cycle();
        end
        rstn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
